kf_iter_sched: RTL and testbench
================================

KF_ITER_SCHED -- requirements
Module: kf_iter_sched

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles a stage may run after its start pulse before it is declared hung.
REQ-002 Parameter CNT_W, default 16: width of the iteration counter.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 step_req  input  1  request one filter iteration; sampled every cycle.
REQ-006 meas_valid  input  1  measurement present for this iteration; sampled with the accepted step_req.
REQ-007 clr_err  input  1  clears the ERR state and error outputs.
REQ-008 pred_start / gain_start / upd_start / post_start  output  1 each  one-cycle start pulses to the predict, gain, state-update and posterior-covariance stages.
REQ-009 pred_done / gain_done / upd_done / post_done  input  1 each  stage completion, level or pulse.
REQ-010 busy  output  1  high in every state except IDLE and ERR.
REQ-011 step_done  output  1  one-cycle pulse at iteration completion.
REQ-012 skipped  output  1  valid with step_done; 1 when the update stages were bypassed.
REQ-013 err  output  1  sticky hang flag.
REQ-014 err_code  output  2  hung stage: 0 PRED, 1 GAIN, 2 UPD, 3 POST.
REQ-015 overrun  output  1  sticky; a request was dropped.
REQ-016 iter_cnt  output  CNT_W  completed iterations, including skipped ones.

Function
REQ-017 FSM states: IDLE, PRED, GAIN, UPDPOST, FIN, ERR; all outputs are registered.
REQ-018 IDLE with step_req=1 -> PRED next cycle; pred_start=1 in the first PRED cycle only; meas_valid is latched at that edge.
REQ-019 Stage completion: a done input is ignored in the cycle its start is high and honoured from the following cycle.
REQ-020 PRED, done honoured: go to GAIN (gain_start pulses on entry) if latched meas_valid=1, else go to FIN.
REQ-021 GAIN, done honoured: go to UPDPOST; upd_start and post_start pulse together on entry.
REQ-022 UPDPOST: upd_done and post_done are captured into sticky flags; leave for FIN the cycle after both flags are set, in either order or simultaneously.
REQ-023 FIN lasts one cycle: step_done=1, skipped=!latched meas_valid, iter_cnt increments modulo 2^CNT_W; then return to IDLE.
REQ-024 Watchdog: a per-stage cycle counter clears on stage entry. If it reaches TIMEOUT before the stage completes, go to ERR with err=1 and err_code=stage. In UPDPOST, err_code is UPD if upd is not yet done, otherwise POST.
REQ-025 A done input and the timeout in the same cycle: done wins.
REQ-026 ERR: all start outputs are 0, busy=0, step_req is ignored. clr_err -> IDLE next cycle with err=0 and err_code=0.
REQ-027 step_req while busy=1 sets a one-deep pending flag and latches its meas_valid.
REQ-028 A further step_req while pending is already set sets overrun.
REQ-029 FIN with pending set: go directly to PRED (pending is consumed) instead of IDLE.
REQ-030 step_req high in FIN with no pending: the request counts as pending and is served per REQ-029.
REQ-031 Entering ERR discards pending.
REQ-032 overrun clears only on rst or clr_err.

Reset
REQ-033 While rst=1 at a clock edge: state=IDLE; all start pulses, busy, step_done, skipped, err, overrun, pending and sticky flags are 0; err_code=0; iter_cnt=0; watchdog=0.
REQ-034 Reset mid-iteration aborts without emitting step_done; stages in flight are not notified.

Structure
REQ-035 Shared package kf_pkg holds the state encoding, the stage/err_code constants and the default TIMEOUT.
REQ-036 The watchdog SHALL be one sub-module, kf_stage_wdog (clear, enable, TIMEOUT parameter, expired output).

Verification
REQ-037 Full iteration: step_req at cycle 0, meas_valid=1; mocks assert done 2 cycles after each start. Required: pred_start@1, gain_start@4, upd_start=post_start=1@7, step_done@10 with skipped=0, iter_cnt=1.
REQ-038 No measurement: step_req at cycle 0 with meas_valid=0. Required: pred_start@1, step_done@4 with skipped=1, and gain/upd/post starts never pulse.
REQ-039 Parallel skew: upd_done 1 cycle after upd_start, post_done 7 cycles after post_start (8-cycle covariance block). Required: step_done exactly 1 cycle after post_done is honoured; test the reverse order and simultaneous dones as well.
REQ-040 Hang: gain_done never asserted, TIMEOUT=64. Required: ERR entered 64 cycles after gain_start with err=1, err_code=1, busy=0; clr_err returns to IDLE; the next step completes normally.
REQ-041 Back-to-back: step_req during PRED, then again during GAIN. Required: second iteration's pred_start the cycle after the first step_done, overrun=1, iter_cnt=2.
REQ-042 Reset in UPDPOST: assert rst for 1 cycle. Required: no step_done, all outputs are at reset values, iter_cnt=0.

Source files
------------

// File: rtl/kf_pkg.sv
// Shared definitions for the Kalman-filter iteration scheduler: FSM encoding,
// stage identifiers reported on err_code, and the default watchdog limit.
package kf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PRED    = 3'd1,
      ST_GAIN    = 3'd2,
      ST_UPDPOST = 3'd3,
      ST_FIN     = 3'd4,
      ST_ERR     = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      STG_PRED = 2'd0,
      STG_GAIN = 2'd1,
      STG_UPD  = 2'd2,
      STG_POST = 2'd3
   } stage_t;

   localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/kf_stage_wdog.sv
// Per-stage hang watchdog: a down-counter reloaded on stage entry that flags
// expiry in the TIMEOUT-th cycle the stage has been running.
module kf_stage_wdog
   import kf_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT) + 1;
   // The entry cycle (clear high) is the first stage cycle, so the reload
   // value covers only the remaining TIMEOUT-1 cycles down to zero.
   localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT - 2);

   logic [CW-1:0] remain;

   always_ff @(posedge clk) begin
      if (rst) begin
         remain <= '0;
      end else if (clear) begin
         remain <= RELOAD;
      end else if (enable && (remain != '0)) begin
         remain <= remain - 1'b1;
      end
   end

   assign expired = enable && !clear && (remain == '0);

endmodule

// File: rtl/kf_iter_sched.sv
// Sequences one Kalman-filter iteration through predict, gain and the parallel
// update/posterior stages, with a one-deep request queue and a stage watchdog.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for step_req
//   PRED    | predict stage running
//   GAIN    | gain stage running (only when a measurement is present)
//   UPDPOST | state-update and covariance stages running in parallel
//   FIN     | one-cycle completion: step_done, iter_cnt advances
//   ERR     | a stage hung; waits for clr_err
module kf_iter_sched
   import kf_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step_req,
   input  logic             meas_valid,
   input  logic             clr_err,
   output logic             pred_start,
   output logic             gain_start,
   output logic             upd_start,
   output logic             post_start,
   input  logic             pred_done,
   input  logic             gain_done,
   input  logic             upd_done,
   input  logic             post_done,
   output logic             busy,
   output logic             step_done,
   output logic             skipped,
   output logic             err,
   output logic [1:0]       err_code,
   output logic             overrun,
   output logic [CNT_W-1:0] iter_cnt
);

   state_t state;
   logic   meas_lat;
   logic   pend;
   logic   pend_meas;
   logic   upd_flag;
   logic   post_flag;

   logic   pred_hit;
   logic   gain_hit;
   logic   upd_hit;
   logic   post_hit;
   logic   wdog_clr;
   logic   wdog_en;
   logic   wdog_exp;

   // A done coinciding with its own start pulse belongs to a previous job.
   assign pred_hit = pred_done && !pred_start;
   assign gain_hit = gain_done && !gain_start;
   assign upd_hit  = upd_flag  || (upd_done  && !upd_start);
   assign post_hit = post_flag || (post_done && !post_start);

   assign wdog_clr = pred_start || gain_start || upd_start;
   assign wdog_en  = (state == ST_PRED) || (state == ST_GAIN) || (state == ST_UPDPOST);

   kf_stage_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wdog_clr),
      .enable  (wdog_en),
      .expired (wdog_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         pred_start <= 1'b0;
         gain_start <= 1'b0;
         upd_start  <= 1'b0;
         post_start <= 1'b0;
         busy       <= 1'b0;
         step_done  <= 1'b0;
         skipped    <= 1'b0;
         err        <= 1'b0;
         err_code   <= STG_PRED;
         overrun    <= 1'b0;
         iter_cnt   <= '0;
         meas_lat   <= 1'b0;
         pend       <= 1'b0;
         pend_meas  <= 1'b0;
         upd_flag   <= 1'b0;
         post_flag  <= 1'b0;
      end else begin
         pred_start <= 1'b0;
         gain_start <= 1'b0;
         upd_start  <= 1'b0;
         post_start <= 1'b0;
         step_done  <= 1'b0;
         skipped    <= 1'b0;

         if (step_req && busy) begin
            if (pend) begin
               overrun <= 1'b1;
            end else begin
               pend      <= 1'b1;
               pend_meas <= meas_valid;
            end
         end
         if (clr_err) begin
            overrun <= 1'b0;
         end

         // State transitions below may override the queue update above.
         unique case (state)
            ST_IDLE: begin
               if (step_req) begin
                  state      <= ST_PRED;
                  pred_start <= 1'b1;
                  busy       <= 1'b1;
                  meas_lat   <= meas_valid;
               end
            end

            ST_PRED: begin
               if (pred_hit) begin
                  if (meas_lat) begin
                     state      <= ST_GAIN;
                     gain_start <= 1'b1;
                  end else begin
                     state     <= ST_FIN;
                     step_done <= 1'b1;
                     skipped   <= 1'b1;
                     iter_cnt  <= iter_cnt + 1'b1;
                  end
               end else if (wdog_exp) begin
                  state    <= ST_ERR;
                  busy     <= 1'b0;
                  err      <= 1'b1;
                  err_code <= STG_PRED;
                  pend     <= 1'b0;
               end
            end

            ST_GAIN: begin
               if (gain_hit) begin
                  state      <= ST_UPDPOST;
                  upd_start  <= 1'b1;
                  post_start <= 1'b1;
                  upd_flag   <= 1'b0;
                  post_flag  <= 1'b0;
               end else if (wdog_exp) begin
                  state    <= ST_ERR;
                  busy     <= 1'b0;
                  err      <= 1'b1;
                  err_code <= STG_GAIN;
                  pend     <= 1'b0;
               end
            end

            ST_UPDPOST: begin
               upd_flag  <= upd_hit;
               post_flag <= post_hit;
               if (upd_hit && post_hit) begin
                  state     <= ST_FIN;
                  step_done <= 1'b1;
                  skipped   <= 1'b0;
                  iter_cnt  <= iter_cnt + 1'b1;
               end else if (wdog_exp) begin
                  state    <= ST_ERR;
                  busy     <= 1'b0;
                  err      <= 1'b1;
                  err_code <= upd_hit ? STG_POST : STG_UPD;
                  pend     <= 1'b0;
               end
            end

            ST_FIN: begin
               // A request arriving in FIN itself is served like a queued one.
               if (pend || step_req) begin
                  state      <= ST_PRED;
                  pred_start <= 1'b1;
                  meas_lat   <= pend ? pend_meas : meas_valid;
                  pend       <= 1'b0;
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end

            ST_ERR: begin
               if (clr_err) begin
                  state    <= ST_IDLE;
                  err      <= 1'b0;
                  err_code <= STG_PRED;
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kf_iter_sched.sv
// Self-checking bench for kf_iter_sched: mock stages with programmable latency,
// directed scenarios plus randomized iterations against a timing model.
module tb_kf_iter_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        step_req = 1'b0;
   logic        meas_valid = 1'b0;
   logic        clr_err = 1'b0;
   logic        pred_start, gain_start, upd_start, post_start;
   logic        pred_done = 1'b0, gain_done = 1'b0, upd_done = 1'b0, post_done = 1'b0;
   logic        busy, step_done, skipped, err, overrun;
   logic [1:0]  err_code;
   logic [15:0] iter_cnt;

   kf_iter_sched #(.TIMEOUT(64), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .step_req   (step_req),
      .meas_valid (meas_valid),
      .clr_err    (clr_err),
      .pred_start (pred_start),
      .gain_start (gain_start),
      .upd_start  (upd_start),
      .post_start (post_start),
      .pred_done  (pred_done),
      .gain_done  (gain_done),
      .upd_done   (upd_done),
      .post_done  (post_done),
      .busy       (busy),
      .step_done  (step_done),
      .skipped    (skipped),
      .err        (err),
      .err_code   (err_code),
      .overrun    (overrun),
      .iter_cnt   (iter_cnt)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int exp_iters = 0;

   // Mock stage latencies in cycles after the start pulse; 0 means never done.
   int lat_p = 2, lat_g = 2, lat_u = 2, lat_o = 2;
   int pc = 0, gc = 0, uc = 0, oc = 0;

   int   pred_q[$], gain_q[$], upd_q[$], post_q[$], done_q[$];
   bit   skip_q[$];
   logic [15:0] cnt_q[$];

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (pred_start === 1'b1) pred_q.push_back(cyc);
      if (gain_start === 1'b1) gain_q.push_back(cyc);
      if (upd_start === 1'b1)  upd_q.push_back(cyc);
      if (post_start === 1'b1) post_q.push_back(cyc);
      if (step_done === 1'b1) begin
         done_q.push_back(cyc);
         skip_q.push_back(skipped);
         cnt_q.push_back(iter_cnt);
      end
      pred_done = 1'b0; gain_done = 1'b0; upd_done = 1'b0; post_done = 1'b0;
      if (rst) begin
         pc = 0; gc = 0; uc = 0; oc = 0;
      end else begin
         if (pred_start === 1'b1) pc = lat_p;
         else if (pc > 0) begin pc--; pred_done = (pc == 0); end
         if (gain_start === 1'b1) gc = lat_g;
         else if (gc > 0) begin gc--; gain_done = (gc == 0); end
         if (upd_start === 1'b1) uc = lat_u;
         else if (uc > 0) begin uc--; upd_done = (uc == 0); end
         if (post_start === 1'b1) oc = lat_o;
         else if (oc > 0) begin oc--; post_done = (oc == 0); end
      end
   end

   task automatic next_slot();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      pred_q.delete(); gain_q.delete(); upd_q.delete(); post_q.delete();
      done_q.delete(); skip_q.delete(); cnt_q.delete();
   endtask

   task automatic reset_dut();
      rst = 1'b1; step_req = 1'b0; meas_valid = 1'b0; clr_err = 1'b0;
      next_slot();
      next_slot();
      rst = 1'b0;
      clear_logs();
      exp_iters = 0;
   endtask

   // Model: cycles from pred_start to step_done for one iteration.
   function automatic int iter_len(bit m, int lp, int lg, int lu, int lo);
      return m ? lp + 1 + lg + 1 + ((lu > lo) ? lu : lo) + 1 : lp + 1;
   endfunction

   task automatic do_step(input bit m, input int lp, input int lg, input int lu,
                          input int lo, input int budget, output int t0, output bit tmo);
      lat_p = lp; lat_g = lg; lat_u = lu; lat_o = lo;
      clear_logs();
      next_slot();
      t0 = cyc; step_req = 1'b1; meas_valid = m;
      next_slot();
      step_req = 1'b0; meas_valid = 1'b0;
      tmo = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (done_q.size() > 0) begin tmo = 1'b0; break; end
         next_slot();
      end
   endtask

   task automatic test_reset();
      reset_dut();
      total++; if ({pred_start, gain_start, upd_start, post_start, busy, step_done, skipped, err, overrun} !== 9'b0)
         $display("FAIL reset_flags got=%b exp=0", {pred_start, gain_start, upd_start, post_start, busy, step_done, skipped, err, overrun});
      else passed++;
      total++; if (err_code !== 2'd0) $display("FAIL reset_err_code got=%0d exp=0", err_code); else passed++;
      total++; if (iter_cnt !== 16'd0) $display("FAIL reset_iter_cnt got=%0d exp=0", iter_cnt); else passed++;
   endtask

   task automatic test_full();
      int t0; bit tmo; int got;
      do_step(1'b1, 2, 2, 2, 2, 60, t0, tmo);
      exp_iters++;
      total++; if (tmo) $display("FAIL full_timeout got=none exp=step_done"); else passed++;
      got = (pred_q.size() > 0) ? pred_q[0] - t0 : -1;
      total++; if (got != 1) $display("FAIL full_pred_start got=%0d exp=1", got); else passed++;
      got = (gain_q.size() > 0) ? gain_q[0] - t0 : -1;
      total++; if (got != 4) $display("FAIL full_gain_start got=%0d exp=4", got); else passed++;
      got = (upd_q.size() > 0) ? upd_q[0] - t0 : -1;
      total++; if (got != 7) $display("FAIL full_upd_start got=%0d exp=7", got); else passed++;
      got = (post_q.size() > 0) ? post_q[0] - t0 : -1;
      total++; if (got != 7) $display("FAIL full_post_start got=%0d exp=7", got); else passed++;
      got = (done_q.size() > 0) ? done_q[0] - t0 : -1;
      total++; if (got != 10) $display("FAIL full_step_done got=%0d exp=10", got); else passed++;
      total++; if (skip_q.size() == 0 || skip_q[0] !== 1'b0) $display("FAIL full_skipped got=%0d exp=0", (skip_q.size() > 0) ? skip_q[0] : 1'b1); else passed++;
      total++; if (cnt_q.size() == 0 || cnt_q[0] !== 16'(exp_iters)) $display("FAIL full_iter_cnt got=%0d exp=%0d", (cnt_q.size() > 0) ? cnt_q[0] : 16'hffff, exp_iters); else passed++;
   endtask

   task automatic test_no_meas();
      int t0; bit tmo; int got;
      do_step(1'b0, 2, 2, 2, 2, 60, t0, tmo);
      exp_iters++;
      next_slot(); next_slot(); next_slot();
      total++; if (tmo) $display("FAIL nomeas_timeout got=none exp=step_done"); else passed++;
      got = (pred_q.size() > 0) ? pred_q[0] - t0 : -1;
      total++; if (got != 1) $display("FAIL nomeas_pred_start got=%0d exp=1", got); else passed++;
      got = (done_q.size() > 0) ? done_q[0] - t0 : -1;
      total++; if (got != 4) $display("FAIL nomeas_step_done got=%0d exp=4", got); else passed++;
      total++; if (skip_q.size() == 0 || skip_q[0] !== 1'b1) $display("FAIL nomeas_skipped got=0 exp=1"); else passed++;
      got = gain_q.size() + upd_q.size() + post_q.size();
      total++; if (got != 0) $display("FAIL nomeas_extra_starts got=%0d exp=0", got); else passed++;
      total++; if (cnt_q.size() == 0 || cnt_q[0] !== 16'(exp_iters)) $display("FAIL nomeas_iter_cnt exp=%0d", exp_iters); else passed++;
   endtask

   task automatic test_skew();
      int t0; bit tmo; int got;
      int lus[3] = '{1, 7, 3};
      int los[3] = '{7, 1, 3};
      for (int k = 0; k < 3; k++) begin
         do_step(1'b1, 2, 2, lus[k], los[k], 60, t0, tmo);
         exp_iters++;
         got = (done_q.size() > 0) ? done_q[0] - t0 : -1;
         total++; if (tmo || got != 7 + ((lus[k] > los[k]) ? lus[k] : los[k]) + 1)
            $display("FAIL skew%0d_step_done got=%0d exp=%0d", k, got, 7 + ((lus[k] > los[k]) ? lus[k] : los[k]) + 1);
         else passed++;
      end
   endtask

   task automatic test_hang();
      int t0; bit tmo; int got; bit seen;
      lat_p = 2; lat_g = 0; lat_u = 2; lat_o = 2;
      clear_logs();
      next_slot();
      t0 = cyc; step_req = 1'b1; meas_valid = 1'b1;
      next_slot();
      step_req = 1'b0; meas_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 150; i++) begin
         if (err === 1'b1) begin seen = 1'b1; break; end
         next_slot();
      end
      got = seen ? cyc - t0 : -1;
      total++; if (got != 68) $display("FAIL hang_err_cycle got=%0d exp=68", got); else passed++;
      total++; if (err_code !== 2'd1) $display("FAIL hang_err_code got=%0d exp=1", err_code); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL hang_busy got=%b exp=0", busy); else passed++;
      total++; if (done_q.size() != 0) $display("FAIL hang_step_done got=%0d exp=0", done_q.size()); else passed++;
      step_req = 1'b1; meas_valid = 1'b1;
      next_slot(); next_slot();
      step_req = 1'b0; meas_valid = 1'b0;
      total++; if (pred_q.size() != 1 || busy !== 1'b0 || err !== 1'b1)
         $display("FAIL hang_req_ignored got=%0d,%b,%b exp=1,0,1", pred_q.size(), busy, err);
      else passed++;
      clr_err = 1'b1;
      next_slot();
      clr_err = 1'b0;
      total++; if ({err, err_code, busy} !== 4'b0) $display("FAIL hang_clr got=%b exp=0000", {err, err_code, busy}); else passed++;
      do_step(1'b1, 2, 2, 2, 2, 60, t0, tmo);
      exp_iters++;
      got = (done_q.size() > 0) ? done_q[0] - t0 : -1;
      total++; if (tmo || got != 10) $display("FAIL hang_recover got=%0d exp=10", got); else passed++;
      total++; if (cnt_q.size() == 0 || cnt_q[0] !== 16'(exp_iters)) $display("FAIL hang_recover_cnt exp=%0d", exp_iters); else passed++;
   endtask

   task automatic test_random();
      for (int it = 0; it < 12; it++) begin
         int lp, lg, lu, lo, t0, tr, nexp, gap;
         bit m1, m2, extra, tmo;
         int e_pred[2], e_done[2];
         bit e_skip[2];
         lp = $urandom_range(6, 1); lg = $urandom_range(6, 1);
         lu = $urandom_range(6, 1); lo = $urandom_range(6, 1);
         m1 = 1'($urandom_range(1, 0)); m2 = 1'($urandom_range(1, 0));
         extra = 1'($urandom_range(1, 0));
         gap = $urandom_range(3, 0);
         lat_p = lp; lat_g = lg; lat_u = lu; lat_o = lo;
         for (int g = 0; g < gap; g++) next_slot();
         clear_logs();
         next_slot();
         t0 = cyc;
         e_pred[0] = t0 + 1;
         e_done[0] = e_pred[0] + iter_len(m1, lp, lg, lu, lo);
         e_skip[0] = !m1;
         tr = $urandom_range(e_done[0], t0 + 1);
         e_pred[1] = e_done[0] + 1;
         e_done[1] = e_pred[1] + iter_len(m2, lp, lg, lu, lo);
         e_skip[1] = !m2;
         nexp = extra ? 2 : 1;
         tmo = 1'b1;
         for (int i = 0; i < 120; i++) begin
            step_req   = (cyc == t0) || (extra && cyc == tr);
            meas_valid = (cyc == t0) ? m1 : m2;
            if (done_q.size() >= nexp) begin tmo = 1'b0; break; end
            next_slot();
         end
         step_req = 1'b0; meas_valid = 1'b0;
         next_slot();
         total++; if (tmo) $display("FAIL rand%0d_timeout got=%0d exp=%0d", it, done_q.size(), nexp); else passed++;
         for (int k = 0; k < nexp; k++) begin
            exp_iters++;
            if (k < done_q.size()) begin
               total++; if (pred_q[k] != e_pred[k]) $display("FAIL rand%0d_pred%0d got=%0d exp=%0d", it, k, pred_q[k], e_pred[k]); else passed++;
               total++; if (done_q[k] != e_done[k]) $display("FAIL rand%0d_done%0d got=%0d exp=%0d", it, k, done_q[k], e_done[k]); else passed++;
               total++; if (skip_q[k] !== e_skip[k]) $display("FAIL rand%0d_skip%0d got=%0d exp=%0d", it, k, skip_q[k], e_skip[k]); else passed++;
               total++; if (cnt_q[k] !== 16'(exp_iters)) $display("FAIL rand%0d_cnt%0d got=%0d exp=%0d", it, k, cnt_q[k], exp_iters); else passed++;
            end
         end
         total++; if (overrun !== 1'b0) $display("FAIL rand%0d_overrun got=%b exp=0", it, overrun); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      int t0; bit tmo; int got;
      lat_p = 2; lat_g = 2; lat_u = 2; lat_o = 2;
      clear_logs();
      next_slot();
      t0 = cyc;
      tmo = 1'b1;
      for (int i = 0; i < 80; i++) begin
         step_req   = (cyc == t0) || (cyc == t0 + 2) || (cyc == t0 + 5);
         meas_valid = (cyc == t0) || (cyc == t0 + 5);
         if (done_q.size() >= 2) begin tmo = 1'b0; break; end
         next_slot();
      end
      step_req = 1'b0; meas_valid = 1'b0;
      next_slot();
      total++; if (tmo) $display("FAIL b2b_timeout got=%0d exp=2", done_q.size()); else passed++;
      got = (done_q.size() > 0) ? done_q[0] - t0 : -1;
      total++; if (got != 10) $display("FAIL b2b_first_done got=%0d exp=10", got); else passed++;
      got = (pred_q.size() > 1) ? pred_q[1] - t0 : -1;
      total++; if (got != 11) $display("FAIL b2b_second_pred got=%0d exp=11", got); else passed++;
      got = (done_q.size() > 1) ? done_q[1] - t0 : -1;
      total++; if (got != 14) $display("FAIL b2b_second_done got=%0d exp=14", got); else passed++;
      total++; if (skip_q.size() < 2 || skip_q[1] !== 1'b1) $display("FAIL b2b_second_skipped got=0 exp=1"); else passed++;
      total++; if (overrun !== 1'b1) $display("FAIL b2b_overrun got=%b exp=1", overrun); else passed++;
      exp_iters += 2;
      total++; if (iter_cnt !== 16'(exp_iters)) $display("FAIL b2b_iter_cnt got=%0d exp=%0d", iter_cnt, exp_iters); else passed++;
   endtask

   task automatic test_reset_mid();
      int t0;
      reset_dut();
      lat_p = 2; lat_g = 2; lat_u = 2; lat_o = 2;
      next_slot();
      t0 = cyc; step_req = 1'b1; meas_valid = 1'b1;
      next_slot();
      step_req = 1'b0; meas_valid = 1'b0;
      while (cyc < t0 + 8) next_slot();
      total++; if (upd_q.size() != 1 || busy !== 1'b1) $display("FAIL rstmid_in_updpost got=%0d,%b exp=1,1", upd_q.size(), busy); else passed++;
      rst = 1'b1;
      next_slot();
      rst = 1'b0;
      total++; if ({pred_start, gain_start, upd_start, post_start, busy, step_done, skipped, err, overrun, err_code} !== 11'b0)
         $display("FAIL rstmid_outputs got=%b exp=0", {pred_start, gain_start, upd_start, post_start, busy, step_done, skipped, err, overrun, err_code});
      else passed++;
      total++; if (iter_cnt !== 16'd0) $display("FAIL rstmid_iter_cnt got=%0d exp=0", iter_cnt); else passed++;
      for (int i = 0; i < 12; i++) next_slot();
      total++; if (done_q.size() != 0 || busy !== 1'b0) $display("FAIL rstmid_no_done got=%0d,%b exp=0,0", done_q.size(), busy); else passed++;
   endtask

   initial begin
      test_reset();
      test_full();
      test_no_meas();
      test_skew();
      test_hang();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
